// File: rtl/gshare_btb_predictor.sv
// gshare direction predictor + set-associative BTB with speculative history.
// Ports: clk/rst, fetch lookup (fetchValid/fetchPc -> fetchHit/fetchTarget/fetchGhr),
//   EX training (exBranch/exTaken/exPc/exTarget/exGhr/exMispredict), initDone.
module gshare_btb_predictor #(
  parameter int BTB_SETS    = 16,
  parameter int BTB_WAYS    = 2,
  parameter int PHT_ENTRIES = 256,
  parameter int GHR_WIDTH   = 8,
  parameter int CTR_BITS    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetchValid,
  input  logic [31:0]          fetchPc,
  output logic                 fetchHit,
  output logic [31:0]          fetchTarget,
  output logic [GHR_WIDTH-1:0] fetchGhr,
  input  logic                 exBranch,
  input  logic                 exTaken,
  input  logic [31:0]          exPc,
  input  logic [31:0]          exTarget,
  input  logic [GHR_WIDTH-1:0] exGhr,
  input  logic                 exMispredict,
  output logic                 initDone
);

  localparam int SET_BITS = $clog2(BTB_SETS);
  localparam int TAG_BITS = 30 - SET_BITS;
  localparam int PHT_BITS = $clog2(PHT_ENTRIES);
  localparam int WAY_BITS = (BTB_WAYS > 1) ? $clog2(BTB_WAYS) : 1;
  localparam int N =
    (PHT_ENTRIES > BTB_SETS) ? PHT_ENTRIES : BTB_SETS;
  localparam int CNT_BITS = $clog2(N);

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WNT =
    CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] SWEEP_LAST = CNT_BITS'(N - 1);
  localparam logic [CNT_BITS:0] SETS_LIM =
    (CNT_BITS + 1)'(BTB_SETS);
  localparam logic [CNT_BITS:0] PHT_LIM =
    (CNT_BITS + 1)'(PHT_ENTRIES);
  localparam logic [WAY_BITS-1:0] WAY_LAST =
    WAY_BITS'(BTB_WAYS - 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_BITS-1:0]  sweep;
  logic [GHR_WIDTH-1:0] ghr;

  logic [CTR_BITS-1:0] pht [PHT_ENTRIES];
  logic [BTB_WAYS-1:0] valid [BTB_SETS];
  logic [TAG_BITS-1:0] tag_mem [BTB_SETS][BTB_WAYS];
  logic [31:0]         tgt_mem [BTB_SETS][BTB_WAYS];
  logic [WAY_BITS-1:0] rr [BTB_SETS];

  // Shift a new outcome into the history; for a 1-bit
  // history this simply loads the bit.
  function automatic logic [GHR_WIDTH-1:0] shift_in(
    input logic [GHR_WIDTH-1:0] h,
    input logic                 b
  );
    logic [GHR_WIDTH-1:0] r;
    r    = h << 1;
    r[0] = b;
    return r;
  endfunction

  logic run;
  assign run = (state == S_RUN);

  // Fetch lookup
  logic [SET_BITS-1:0] f_set;
  logic [TAG_BITS-1:0] f_tag;
  logic [PHT_BITS-1:0] f_idx;
  logic                f_hit;
  logic [WAY_BITS-1:0] f_way;
  logic                f_taken;

  assign f_set   = fetchPc[SET_BITS+1:2];
  assign f_tag   = fetchPc[31:SET_BITS+2];
  assign f_idx   = fetchPc[PHT_BITS+1:2] ^ PHT_BITS'(ghr);
  assign f_taken = pht[f_idx][CTR_BITS-1];

  always_comb begin
    f_hit = 1'b0;
    f_way = '0;
    for (int w = 0; w < BTB_WAYS; w++) begin
      if (valid[f_set][w] && tag_mem[f_set][w] == f_tag) begin
        f_hit = 1'b1;
        f_way = WAY_BITS'(w);
      end
    end
  end

  assign fetchHit    = run & f_hit & f_taken;
  assign fetchTarget = f_hit ? tgt_mem[f_set][f_way] : '0;
  assign fetchGhr    = ghr;
  assign initDone    = run;

  // EX update lookup
  logic [SET_BITS-1:0] u_set;
  logic [TAG_BITS-1:0] u_tag;
  logic [PHT_BITS-1:0] u_idx;
  logic                u_hit;
  logic [WAY_BITS-1:0] u_way;
  logic                u_inv;
  logic [WAY_BITS-1:0] u_inv_way;
  logic [WAY_BITS-1:0] victim;
  logic [CTR_BITS-1:0] ctr;
  logic [CTR_BITS-1:0] ctr_nxt;
  logic                upd;
  logic                recover;

  assign u_set   = exPc[SET_BITS+1:2];
  assign u_tag   = exPc[31:SET_BITS+2];
  assign u_idx   = exPc[PHT_BITS+1:2] ^ PHT_BITS'(exGhr);
  assign upd     = run & exBranch;
  assign recover = upd & exMispredict;
  assign ctr     = pht[u_idx];

  always_comb begin
    u_hit     = 1'b0;
    u_way     = '0;
    u_inv     = 1'b0;
    u_inv_way = '0;
    for (int w = 0; w < BTB_WAYS; w++) begin
      if (valid[u_set][w] && tag_mem[u_set][w] == u_tag) begin
        u_hit = 1'b1;
        u_way = WAY_BITS'(w);
      end
    end
    // Descending scan leaves the lowest invalid way selected.
    for (int w = BTB_WAYS - 1; w >= 0; w--) begin
      if (!valid[u_set][w]) begin
        u_inv     = 1'b1;
        u_inv_way = WAY_BITS'(w);
      end
    end
  end

  assign victim = u_inv ? u_inv_way : rr[u_set];

  always_comb begin
    ctr_nxt = ctr;
    if (exTaken) begin
      if (ctr != CTR_MAX) ctr_nxt = ctr + CTR_BITS'(1);
    end else begin
      if (ctr != '0) ctr_nxt = ctr - CTR_BITS'(1);
    end
  end

  // FSM
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_INIT: if (sweep == SWEEP_LAST) state_nxt = S_RUN;
      S_RUN:  state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      sweep <= '0;
      ghr   <= '0;
    end else begin
      state <= state_nxt;
      if (!run) begin
        sweep <= sweep + CNT_BITS'(1);
        ghr   <= '0;
      end else if (recover) begin
        ghr <= shift_in(exGhr, exTaken);
      end else if (fetchValid && f_hit) begin
        ghr <= shift_in(ghr, f_taken);
      end
    end
  end

  // Tables carry no reset; the INIT sweep rebuilds them.
  always_ff @(posedge clk) begin
    if (!run) begin
      if ({1'b0, sweep} < PHT_LIM)
        pht[sweep[PHT_BITS-1:0]] <= CTR_WNT;
      if ({1'b0, sweep} < SETS_LIM) begin
        valid[sweep[SET_BITS-1:0]] <= '0;
        rr[sweep[SET_BITS-1:0]]    <= '0;
      end
    end else if (upd) begin
      pht[u_idx] <= ctr_nxt;
      if (exTaken) begin
        if (u_hit) begin
          tgt_mem[u_set][u_way] <= exTarget;
        end else begin
          valid[u_set][victim]   <= 1'b1;
          tag_mem[u_set][victim] <= u_tag;
          tgt_mem[u_set][victim] <= exTarget;
          rr[u_set] <= (rr[u_set] == WAY_LAST)
                       ? '0 : rr[u_set] + WAY_BITS'(1);
        end
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{fetchPc[1:0], exPc[1:0], sweep};

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Scoreboard bench for gshare_btb_predictor (default parameters).
// Stimulus pushes expected fetch responses; a negedge monitor checks them.
module tb_gshare_btb_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetchValid = 1'b0;
  logic [31:0] fetchPc = '0;
  logic        fetchHit;
  logic [31:0] fetchTarget;
  logic [7:0]  fetchGhr;
  logic        exBranch = 1'b0;
  logic        exTaken = 1'b0;
  logic [31:0] exPc = '0;
  logic [31:0] exTarget = '0;
  logic [7:0]  exGhr = '0;
  logic        exMispredict = 1'b0;
  logic        initDone;
  logic        probe = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic        init;
    logic        hit;
    logic [31:0] tgt;
    logic [7:0]  ghr;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  gshare_btb_predictor dut (
    .clk(clk),
    .rst(rst),
    .fetchValid(fetchValid),
    .fetchPc(fetchPc),
    .fetchHit(fetchHit),
    .fetchTarget(fetchTarget),
    .fetchGhr(fetchGhr),
    .exBranch(exBranch),
    .exTaken(exTaken),
    .exPc(exPc),
    .exTarget(exTarget),
    .exGhr(exGhr),
    .exMispredict(exMispredict),
    .initDone(initDone)
  );

  function automatic exp_t mk(
    input int id, input logic init, input logic hit,
    input logic [31:0] tgt, input logic [7:0] ghr
  );
    exp_t e;
    e.id = id; e.init = init; e.hit = hit;
    e.tgt = tgt; e.ghr = ghr;
    return e;
  endfunction

  task automatic step(
    input logic r,
    input logic fv, input logic [31:0] fpc,
    input logic eb, input logic et, input logic em,
    input logic [31:0] epc, input logic [31:0] etg,
    input logic [7:0] eg,
    input logic pr, input exp_t e
  );
    @(posedge clk);
    #1;
    rst = r;
    fetchValid = fv; fetchPc = fpc;
    exBranch = eb; exTaken = et; exMispredict = em;
    exPc = epc; exTarget = etg; exGhr = eg;
    probe = pr;
    if (pr) sbq.push_back(e);
  endtask

  exp_t nx;

  always @(negedge clk) begin
    if (probe) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty got probe with no expectation");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (initDone !== e.init) begin
          errors++;
          $display("FAIL init id=%0d got %b want %b",
                   e.id, initDone, e.init);
        end
        checks++;
        if (fetchHit !== e.hit) begin
          errors++;
          $display("FAIL hit id=%0d got %b want %b",
                   e.id, fetchHit, e.hit);
        end
        checks++;
        if (fetchGhr !== e.ghr) begin
          errors++;
          $display("FAIL ghr id=%0d got %h want %h",
                   e.id, fetchGhr, e.ghr);
        end
        if (e.hit) begin
          checks++;
          if (fetchTarget !== e.tgt) begin
            errors++;
            $display("FAIL target id=%0d got %h want %h",
                     e.id, fetchTarget, e.tgt);
          end
        end
      end
    end
  end

  initial begin
    nx = mk(0, 0, 0, 0, 0);
    // Held in reset
    for (int i = 0; i < 3; i++)
      step(1, 1, 32'h100, 0, 0, 0, 0, 0, 0, 1, mk(100, 0, 0, 0, 0));
    // INIT: cycles 0..255 keep initDone=0, no hits, GHR 0
    for (int i = 0; i < 256; i++)
      step(0, 1, 32'(i * 4), 0, 0, 0, 0, 0, 0, 1,
           mk(1000 + i, 0, 0, 0, 0));
    // Cycle 256: active, cold table
    step(0, 1, 32'h104, 0, 0, 0, 0, 0, 0, 1, mk(1, 1, 0, 0, 0));
    // Train taken 0x104 -> 0x200; concurrent fetch sees pre-update
    step(0, 1, 32'h104, 1, 1, 0, 32'h104, 32'h200, 0, 1,
         mk(2, 1, 0, 0, 0));
    step(0, 0, 0, 1, 1, 0, 32'h104, 32'h200, 0, 0, nx);
    step(0, 0, 0, 1, 1, 0, 32'h104, 32'h200, 0, 0, nx);
    // Counter saturated at 3 -> taken hit, GHR becomes 0x01
    step(0, 1, 32'h104, 0, 0, 0, 0, 0, 0, 1,
         mk(3, 1, 1, 32'h200, 0));
    // Two not-taken: 3->2->1, second recovers GHR to 0
    step(0, 0, 0, 1, 0, 0, 32'h104, 32'h200, 0, 0, nx);
    step(0, 0, 0, 1, 0, 1, 32'h104, 32'h200, 0, 0, nx);
    // BTB hit, predicted not taken; shifts 0 into GHR
    step(0, 1, 32'h104, 0, 0, 0, 0, 0, 0, 1, mk(4, 1, 0, 0, 0));
    // Set conflict in set 0
    step(0, 0, 0, 1, 1, 0, 32'h000, 32'h1000, 0, 0, nx);
    step(0, 0, 0, 1, 1, 0, 32'h040, 32'h1040, 0, 0, nx);
    step(0, 0, 0, 1, 1, 0, 32'h080, 32'h1080, 0, 0, nx);
    // Fetch with same-cycle recovery keeps GHR at 0
    step(0, 1, 32'h040, 1, 0, 1, 32'h3F0, 0, 0, 1,
         mk(5, 1, 1, 32'h1040, 0));
    step(0, 1, 32'h080, 1, 0, 1, 32'h3F0, 0, 0, 1,
         mk(6, 1, 1, 32'h1080, 0));
    step(0, 1, 32'h000, 1, 0, 1, 32'h3F0, 0, 0, 1,
         mk(7, 1, 0, 0, 0));
    // Recover to 0x55, then a not-taken BTB hit shifts to 0xAA
    step(0, 0, 0, 1, 1, 1, 32'h3F0, 0, 8'h2A, 0, nx);
    step(0, 1, 32'h040, 0, 0, 0, 0, 0, 0, 1,
         mk(8, 1, 0, 0, 8'h55));
    // Mispredict exGhr=0x0F taken overrides concurrent fetch shift
    step(0, 1, 32'h040, 1, 1, 1, 32'h3F0, 0, 8'h0F, 1,
         mk(9, 1, 0, 0, 8'hAA));
    step(0, 1, 32'h000, 0, 0, 0, 0, 0, 0, 1,
         mk(10, 1, 0, 0, 8'h1F));
    // exMispredict without exBranch is ignored
    step(0, 0, 0, 0, 0, 1, 32'h3F0, 0, 8'h00, 0, nx);
    step(0, 1, 32'h000, 0, 0, 0, 0, 0, 0, 1,
         mk(11, 1, 0, 0, 8'h1F));
    // Recover GHR to 0, then rst during a trained hit
    step(0, 0, 0, 1, 0, 1, 32'h3F0, 0, 0, 0, nx);
    step(1, 1, 32'h040, 0, 0, 0, 0, 0, 0, 1,
         mk(12, 1, 1, 32'h1040, 0));
    step(0, 1, 32'h040, 0, 0, 0, 0, 0, 0, 1,
         mk(13, 0, 0, 0, 0));
    for (int i = 1; i < 255; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, nx);
    step(0, 1, 32'h040, 0, 0, 0, 0, 0, 0, 1,
         mk(14, 0, 0, 0, 0));
    step(0, 1, 32'h040, 0, 0, 0, 0, 0, 0, 1,
         mk(15, 1, 0, 0, 0));
    step(0, 1, 32'h104, 0, 0, 0, 0, 0, 0, 1,
         mk(16, 1, 0, 0, 0));
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, nx);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, nx);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d entries want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
